// File: rtl/rpspmc_scale_pkg.sv
// rtl/rpspmc_scale_pkg.sv - shared widths, saturation limits and stage-1 record for the shift/scale arbiter
package rpspmc_scale_pkg;

    localparam int IN_W_DEF      = 32;
    localparam int OUT_W_DEF     = 23;
    localparam int SHIFT_W_DEF   = 6;
    localparam int ID_W_DEF      = 2;
    localparam int SHIFT_RST_DEF = 8;

    // Output range at the default OUT_W
    localparam longint OUT_MAX = (longint'(1) << (OUT_W_DEF - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) << (OUT_W_DEF - 1));

    // Accepted sample waiting for the shift core, at default widths
    typedef struct packed {
        logic                          valid;
        logic [ID_W_DEF-1:0]           id;
        logic signed [IN_W_DEF-1:0]    data;
        logic signed [SHIFT_W_DEF-1:0] shift;
    } stage1_t;

endpackage

// File: rtl/sat_shift_core.sv
// rtl/sat_shift_core.sv - combinational signed shift with saturation to OUT_W
module sat_shift_core
    import rpspmc_scale_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic signed [IN_W-1:0]    i_x,
    input  logic signed [SHIFT_W-1:0] i_k,
    output logic signed [OUT_W-1:0]   o_y,
    output logic                      o_sat
);

    // 32 guard bits hold the largest left shift without overflow
    localparam int WW = IN_W + 32;
    localparam logic signed [WW-1:0] W_MAX = {{(WW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [WW-1:0] W_MIN = ~W_MAX;

    logic signed [WW-1:0] w_ext;
    logic signed [WW-1:0] w_shifted;
    logic [SHIFT_W-1:0]   w_mag;

    // Shift in the wide domain, then clip; >>> rounds toward -inf and fills with sign for large shifts
    always_comb begin
        w_ext = WW'(i_x);
        w_mag = i_k[SHIFT_W-1] ? (~i_k + 1'b1) : i_k;
        if (i_k[SHIFT_W-1]) begin
            w_shifted = w_ext >>> w_mag;
        end else begin
            w_shifted = w_ext <<< w_mag;
        end
        if (w_shifted > W_MAX) begin
            o_y   = W_MAX[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (w_shifted < W_MIN) begin
            o_y   = W_MIN[OUT_W-1:0];
            o_sat = 1'b1;
        end else begin
            o_y   = w_shifted[OUT_W-1:0];
            o_sat = 1'b0;
        end
    end

endmodule

// File: rtl/shift_scale_arbiter.sv
// rtl/shift_scale_arbiter.sv - round-robin shared saturating shift/scale unit with tagged output stream
module shift_scale_arbiter
    import rpspmc_scale_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int SHIFT_W   = SHIFT_W_DEF,
    parameter int SHIFT_RST = SHIFT_RST_DEF,
    parameter int ID_W      = ID_W_DEF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ-1:0]          s_valid,
    output logic [N_REQ-1:0]          s_ready,
    input  logic [N_REQ*IN_W-1:0]     s_data,
    input  logic                      cfg_we,
    input  logic [ID_W-1:0]           cfg_sel,
    input  logic signed [SHIFT_W-1:0] cfg_shift,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [OUT_W-1:0]   m_data,
    output logic [ID_W-1:0]           m_id,
    output logic                      m_sat
);

    typedef struct packed {
        logic                      valid;
        logic [ID_W-1:0]           id;
        logic signed [IN_W-1:0]    data;
        logic signed [SHIFT_W-1:0] shift;
    } s1_t;

    logic signed [SHIFT_W-1:0] r_shift [N_REQ];
    logic [ID_W-1:0]           r_ptr;
    s1_t                       r_s1;
    logic                      r_m_valid;
    logic signed [OUT_W-1:0]   r_m_data;
    logic [ID_W-1:0]           r_m_id;
    logic                      r_m_sat;

    logic                      w_en;
    logic                      w_found;
    logic                      w_xfer;
    logic [ID_W-1:0]           w_grant_id;
    int                        w_cand;
    logic signed [OUT_W-1:0]   w_y;
    logic                      w_sat;

    // Whole pipeline advances only when the output slot is empty or being taken
    assign w_en   = aresetn & (~r_m_valid | m_ready);
    assign w_xfer = w_found & w_en;

    // Round-robin search starting just after the last winner
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = r_ptr;
        w_cand     = 0;
        for (int j = 1; j <= N_REQ; j++) begin
            w_cand = (int'(r_ptr) + j) % N_REQ;
            if (!w_found && s_valid[w_cand]) begin
                w_found    = 1'b1;
                w_grant_id = ID_W'(w_cand);
            end
        end
    end

    // Grant is one-hot and withheld entirely while stalled
    always_comb begin
        s_ready = '0;
        if (w_xfer) begin
            s_ready = N_REQ'(1) << w_grant_id;
        end
    end

    // Per-requester shift amounts; out-of-range selects are dropped
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_shift[i] <= SHIFT_W'(SHIFT_RST);
            end
        end else if (cfg_we && (int'(cfg_sel) < N_REQ)) begin
            r_shift[cfg_sel] <= cfg_shift;
        end
    end

    // Last winner, moved only on a real handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_grant_id;
        end
    end

    // Stage 1 captures the winner's sample and its pre-edge shift value
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1 <= '0;
        end else if (w_en) begin
            r_s1.valid <= w_xfer;
            if (w_xfer) begin
                r_s1.id    <= w_grant_id;
                r_s1.data  <= s_data[int'(w_grant_id)*IN_W +: IN_W];
                r_s1.shift <= r_shift[w_grant_id];
            end
        end
    end

    sat_shift_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_core (
        .i_x   (r_s1.data),
        .i_k   (r_s1.shift),
        .o_y   (w_y),
        .o_sat (w_sat)
    );

    // Output register; data fields hold when a bubble passes through
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_id    <= '0;
            r_m_sat   <= 1'b0;
        end else if (w_en) begin
            r_m_valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_m_data <= w_y;
                r_m_id   <= r_s1.id;
                r_m_sat  <= w_sat;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_id    = r_m_id;
    assign m_sat   = r_m_sat;

endmodule
